// File: rtl/ver_line_blend.sv
// Vertical line store and two-line blender: three rotating RGB888 line banks, 4-stage blend pipeline.
// Build option: define LINE_BLEND_ROUND_EN for round-half-up blending; otherwise results truncate.
module ver_line_blend #(
    parameter int LINE_W = 800,
    parameter int AW     = 10
) (
    input  logic        iCLK,
    input  logic        iRSTN,
    input  logic        iLATCH,
    input  logic        iLINE_START,
    input  logic [6:0]  iWEIGHT,
    input  logic [23:0] iSRC_DATA,
    input  logic        iSRC_VALID,
    output logic        oSRC_REQ,
    output logic [23:0] oPIX_DATA,
    output logic        oPIX_VALID,
    output logic        oBUSY,
    output logic        oERR
);

    typedef enum logic [1:0] {CAP_IDLE, CAP_FILL, CAP_COMMIT} cap_state_t;
    typedef enum logic       {RD_IDLE, RD_READ}               rd_state_t;

    localparam logic [AW-1:0] LAST = AW'(LINE_W - 1);

    cap_state_t    cap_state, cap_next;
    rd_state_t     rd_state,  rd_next;
    logic          pend, pend_next;
    logic          err, err_next;
    logic [AW-1:0] waddr, waddr_next;
    logic [AW-1:0] raddr, raddr_next;
    logic [1:0]    top_ptr, bot_ptr, fill_ptr;
    logic [1:0]    top_next, bot_next, fill_next;
    logic [1:0]    rd_top, rd_bot, rd_top_next, rd_bot_next;
    logic [6:0]    rd_w, rd_w_next;
    logic          wr_en;
    logic          queue_latch;

    logic [23:0]   mem [3][LINE_W];
    logic [23:0]   t_q, b_q;
    logic [6:0]    w_q;
    logic [7:0]    w_inv;
    logic [14:0]   prod_t [3];
    logic [14:0]   prod_b [3];
    logic [15:0]   blend_sum [3];
    logic          v1, v2;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        cap_next    = cap_state;
        rd_next     = rd_state;
        pend_next   = pend;
        err_next    = err;
        waddr_next  = waddr;
        raddr_next  = raddr;
        top_next    = top_ptr;
        bot_next    = bot_ptr;
        fill_next   = fill_ptr;
        rd_top_next = rd_top;
        rd_bot_next = rd_bot;
        rd_w_next   = rd_w;
        wr_en       = 1'b0;
        queue_latch = 1'b0;

        case (rd_state)
            RD_IDLE: if (iLINE_START) begin
                rd_next     = RD_READ;
                raddr_next  = '0;
                rd_w_next   = iWEIGHT;
                rd_top_next = top_ptr;
                rd_bot_next = bot_ptr;
            end
            RD_READ: begin
                if (iLINE_START) err_next = 1'b1;
                if (raddr == LAST) rd_next = RD_IDLE;
                else               raddr_next = raddr + AW'(1);
            end
            default: rd_next = RD_IDLE;
        endcase

        case (cap_state)
            CAP_IDLE: if (iLATCH) begin
                cap_next   = CAP_FILL;
                waddr_next = '0;
            end
            CAP_FILL: begin
                queue_latch = iLATCH;
                if (iSRC_VALID) begin
                    wr_en = 1'b1;
                    if (waddr == LAST) cap_next = CAP_COMMIT;
                    else               waddr_next = waddr + AW'(1);
                end
            end
            CAP_COMMIT: begin
                // A read starting this cycle snapshots the old pair; rotation waits for it to finish.
                if (rd_state == RD_IDLE && !iLINE_START) begin
                    top_next   = bot_ptr;
                    bot_next   = fill_ptr;
                    fill_next  = top_ptr;
                    waddr_next = '0;
                    cap_next   = (pend || iLATCH) ? CAP_FILL : CAP_IDLE;
                    pend_next  = pend && iLATCH;
                end else begin
                    queue_latch = iLATCH;
                end
            end
            default: cap_next = CAP_IDLE;
        endcase

        if (queue_latch) begin
            if (pend) err_next  = 1'b1;
            else      pend_next = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            cap_state <= CAP_IDLE;
            rd_state  <= RD_IDLE;
            pend      <= 1'b0;
            err       <= 1'b0;
            waddr     <= '0;
            raddr     <= '0;
            top_ptr   <= 2'd0;
            bot_ptr   <= 2'd1;
            fill_ptr  <= 2'd2;
            rd_top    <= 2'd0;
            rd_bot    <= 2'd1;
            rd_w      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cap_state <= cap_next;
            rd_state  <= rd_next;
            pend      <= pend_next;
            err       <= err_next;
            waddr     <= waddr_next;
            raddr     <= raddr_next;
            top_ptr   <= top_next;
            bot_ptr   <= bot_next;
            fill_ptr  <= fill_next;
            rd_top    <= rd_top_next;
            rd_bot    <= rd_bot_next;
            rd_w      <= rd_w_next;
        end
    end

    assign w_inv = 8'd128 - {1'b0, w_q};

    // NOTE: line RAM and datapath stages carry no reset; only the valid chain and outputs need one.
    always_ff @(posedge iCLK) begin
        if (wr_en) mem[fill_ptr][waddr] <= iSRC_DATA;
        t_q <= mem[rd_top][raddr];
        b_q <= mem[rd_bot][raddr];
        w_q <= rd_w;
        for (int c = 0; c < 3; c++) begin
            prod_t[c] <= {7'd0, t_q[c*8 +: 8]} * {7'd0, w_inv};
            prod_b[c] <= {7'd0, b_q[c*8 +: 8]} * {8'd0, w_q};
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
`ifdef LINE_BLEND_ROUND_EN
            blend_sum[c] = {1'b0, prod_t[c]} + {1'b0, prod_b[c]} + 16'd64;
`else
            blend_sum[c] = {1'b0, prod_t[c]} + {1'b0, prod_b[c]};
`endif
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            oPIX_VALID <= 1'b0;
            oPIX_DATA  <= '0;
        end else begin
            v1         <= (rd_state == RD_READ);
            v2         <= v1;
            oPIX_VALID <= v2;
            for (int c = 0; c < 3; c++)
                oPIX_DATA[c*8 +: 8] <= 8'(blend_sum[c] >> 7);
        end
    end

    assign oSRC_REQ = (cap_state == CAP_FILL);
    assign oERR     = err;
    assign oBUSY    = (cap_state != CAP_IDLE) || pend || (rd_state == RD_READ)
                   || v1 || v2 || oPIX_VALID;

endmodule

// File: tb/tb_ver_line_blend.sv
// Directed bench for ver_line_blend with LINE_W=8: blend table, deferred commit,
// pending/overflow latch, back-pressure and mid-capture reset.
module tb_ver_line_blend;

    localparam int LINE_W = 8;
    localparam int AW     = 3;
`ifdef LINE_BLEND_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        iCLK;
    logic        iRSTN;
    logic        iLATCH;
    logic        iLINE_START;
    logic [6:0]  iWEIGHT;
    logic [23:0] iSRC_DATA;
    logic        iSRC_VALID;
    logic        oSRC_REQ;
    logic [23:0] oPIX_DATA;
    logic        oPIX_VALID;
    logic        oBUSY;
    logic        oERR;

    int n_vec = 0;
    int n_err = 0;

    ver_line_blend #(.LINE_W(LINE_W), .AW(AW)) dut (
        .iCLK        (iCLK),
        .iRSTN       (iRSTN),
        .iLATCH      (iLATCH),
        .iLINE_START (iLINE_START),
        .iWEIGHT     (iWEIGHT),
        .iSRC_DATA   (iSRC_DATA),
        .iSRC_VALID  (iSRC_VALID),
        .oSRC_REQ    (oSRC_REQ),
        .oPIX_DATA   (oPIX_DATA),
        .oPIX_VALID  (oPIX_VALID),
        .oBUSY       (oBUSY),
        .oERR        (oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [23:0] t;
        logic [23:0] b;
        logic [6:0]  w;
        logic [23:0] exp_rnd;
        logic [23:0] exp_trn;
        string       name;
    } blend_vec_t;

    blend_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (oBUSY && k < 100) begin
            @(negedge iCLK);
            k++;
        end
        check({tag, "_idle"}, oBUSY, 0);
    endtask

    // Writes pixels until LINE_W handshakes complete; iLATCH pulses on iterations inj0/inj1.
    task automatic feed(input logic [23:0] p, input bit toggle, input int inj0, input int inj1);
        int n = 0;
        int k = 0;
        while (n < LINE_W && k < 64) begin
            iSRC_DATA  = p;
            iSRC_VALID = toggle ? ~k[0] : 1'b1;
            iLATCH     = (k == inj0) || (k == inj1);
            if (iSRC_VALID && oSRC_REQ) n++;
            @(negedge iCLK);
            k++;
        end
        iSRC_VALID = 1'b0;
        iLATCH     = 1'b0;
        check("feed_writes", n, LINE_W);
        check("src_req_drop", oSRC_REQ, 0);
    endtask

    task automatic capture(input logic [23:0] p);
        iLATCH = 1'b1;
        @(negedge iCLK);
        iLATCH = 1'b0;
        feed(p, 1'b0, -1, -1);
        wait_idle("capture");
    endtask

    task automatic read_line(input logic [6:0] w, input logic [23:0] exp, input string tag);
        int lat;
        iWEIGHT     = w;
        iLINE_START = 1'b1;
        @(negedge iCLK);
        iLINE_START = 1'b0;
        lat = 1;
        while (!oPIX_VALID && lat < 12) begin
            @(negedge iCLK);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        for (int i = 0; i < LINE_W; i++) begin
            check({tag, "_valid"}, oPIX_VALID, 1);
            check({tag, "_data"}, oPIX_DATA, exp);
            @(negedge iCLK);
        end
        check({tag, "_valid_end"}, oPIX_VALID, 0);
    endtask

    task automatic do_reset(input string tag);
        iRSTN       = 1'b0;
        iLATCH      = 1'b0;
        iLINE_START = 1'b0;
        iSRC_VALID  = 1'b0;
        @(negedge iCLK);
        check({tag, "_src_req"}, oSRC_REQ, 0);
        check({tag, "_pix_valid"}, oPIX_VALID, 0);
        check({tag, "_pix_data"}, oPIX_DATA, 0);
        check({tag, "_busy"}, oBUSY, 0);
        check({tag, "_err"}, oERR, 0);
        iRSTN = 1'b1;
        @(negedge iCLK);
    endtask

    initial begin
        logic [23:0] half;
        iRSTN       = 1'b0;
        iLATCH      = 1'b0;
        iLINE_START = 1'b0;
        iWEIGHT     = '0;
        iSRC_DATA   = '0;
        iSRC_VALID  = 1'b0;
        half        = ROUND ? 24'h808080 : 24'h7F7F7F;
        @(negedge iCLK);
        do_reset("reset");

        // Hand-computed: out = (t*(128-w) + b*w + RND) >> 7 per channel.
        vecs[0] = '{24'h000000, 24'hFFFFFF, 7'd64,  24'h808080, 24'h7F7F7F, "half"};
        vecs[1] = '{24'h102030, 24'hF0E0D0, 7'd0,   24'h102030, 24'h102030, "w0"};
        vecs[2] = '{24'h102030, 24'hF0E0D0, 7'd127, 24'hEEDFCF, 24'hEEDECE, "w127"};
        vecs[3] = '{24'h123456, 24'h123456, 7'd37,  24'h123456, 24'h123456, "equal"};
        vecs[4] = '{24'hFF00FF, 24'h00FF00, 7'd1,   24'hFD02FD, 24'hFD01FD, "w1"};
        vecs[5] = '{24'h0A0B0C, 24'h646464, 7'd96,  24'h4E4E4E, 24'h4D4D4E, "w96"};

        for (int i = 0; i < 6; i++) begin
            capture(vecs[i].t);
            capture(vecs[i].b);
            read_line(vecs[i].w, ROUND ? vecs[i].exp_rnd : vecs[i].exp_trn, vecs[i].name);
        end

        // Capture completes while a line is being read: that line keeps the old pair.
        fork
            capture(24'h000000);
            begin
                repeat (5) @(negedge iCLK);
                read_line(7'd0, 24'h0A0B0C, "defer_old");
            end
        join
        read_line(7'd0, 24'h646464, "defer_new");

        // Back-pressure: 50% valid, then extra valid beats during COMMIT must be dropped.
        iLATCH = 1'b1;
        @(negedge iCLK);
        iLATCH = 1'b0;
        feed(24'h3C5A78, 1'b1, -1, -1);
        iSRC_VALID = 1'b1;
        iSRC_DATA  = 24'hA5A5A5;
        repeat (3) @(negedge iCLK);
        iSRC_VALID = 1'b0;
        wait_idle("bp");
        capture(24'h111111);
        read_line(7'd0, 24'h3C5A78, "bp_line");

        // Pending latch, back-to-back capture, then overflow error.
        iLATCH = 1'b1;
        @(negedge iCLK);
        iLATCH = 1'b0;
        feed(24'h202020, 1'b0, 2, -1);
        @(negedge iCLK);
        check("pend_refill", oSRC_REQ, 1);
        check("pend_no_err", oERR, 0);
        check("pend_busy", oBUSY, 1);
        feed(24'h404040, 1'b0, 0, 1);
        check("overflow_err", oERR, 1);
        @(negedge iCLK);
        check("third_fill", oSRC_REQ, 1);
        feed(24'h606060, 1'b0, -1, -1);
        wait_idle("pend");
        check("err_sticky", oERR, 1);

        // Mid-capture reset: banks 0/1 survive, partial bank 2 is not committed.
        do_reset("rst_a");
        capture(24'h555555);
        capture(24'h000000);
        capture(24'hFFFFFF);
        iLATCH = 1'b1;
        @(negedge iCLK);
        iLATCH = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iSRC_VALID = 1'b1;
            iSRC_DATA  = 24'h777777;
            @(negedge iCLK);
        end
        iSRC_VALID = 1'b0;
        check("partial_src_req", oSRC_REQ, 1);
        do_reset("rst_mid");
        read_line(7'd64, half, "rst_partial");

        // Reset from rotated pointers must return TOP to bank 0.
        capture(24'h333333);
        do_reset("rst_ptr");
        read_line(7'd0, 24'h000000, "rst_top");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
